// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: FWFT buffer of {break, frame_error, data} with sticky overflow.
// Optional registered level flag rx_thresh is enabled by defining UART_RX_FIFO_THRESH_EN.
module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int THRESHOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 wr_data,
    input  logic                       wr_valid,
    input  logic                       wr_frame_error,
    input  logic                       wr_break_valid,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic                       rd_frame_error,
    output logic                       rd_break,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clr_overflow,
    output logic                       rx_thresh
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
    end
    if ((THRESHOLD < 1) || (THRESHOLD > DEPTH)) begin : g_bad_thresh
        $error("uart_rx_fifo: THRESHOLD must be in 1..DEPTH");
    end

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt;
    logic [9:0]    wr_entry;
    logic [9:0]    head;
    logic          push;
    logic          pop;
    logic          accept;
    logic          drop;

    assign push   = wr_valid | wr_break_valid;
    assign pop    = rd_en & ~empty;
    // A full FIFO still takes a push when the same cycle frees the head slot.
    assign accept = push & (~full | pop);
    // Coincident pulses keep the break and lose the byte, which counts as a loss.
    assign drop   = (push & ~accept) | (wr_valid & wr_break_valid);
    assign wr_entry = wr_break_valid ? 10'h200 : {1'b0, wr_frame_error, wr_data};

    always_comb begin
        count_nxt = count;
        if (accept && !pop) begin
            count_nxt = count + CNT_ONE;
        end else if (!accept && pop) begin
            count_nxt = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CNT_FULL);
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_THRESH_EN
    localparam logic [CW-1:0] CNT_THRESH = CW'(THRESHOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_thresh <= 1'b0;
        end else begin
            rx_thresh <= (count_nxt >= CNT_THRESH);
        end
    end
`else
    assign rx_thresh = 1'b0;
`endif

    assign head           = empty ? 10'h000 : mem[rd_ptr];
    assign rd_break       = head[9];
    assign rd_frame_error = head[8];
    assign rd_data        = head[7:0];

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer for the UART that sits directly downstream of the RX shift register. It captures each received byte together with its framing-error flag, and records line-break events as marked entries. It presents them to the bus/CPU side through a first-word-fall-through (FWFT) read port, with occupancy, full/empty and sticky overflow status. Everything runs in the single `clk` domain; the writer's valid pulses are one `clk` wide.

## Interface
- `DEPTH`, 16, number of entries; power of two, ≥ 2.
- `THRESHOLD`, 8, fill level for `rx_thresh`, range 1..DEPTH; used only with `UART_RX_FIFO_THRESH_EN`.

- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_data` in 8: received byte.
- `wr_valid` in 1: one-cycle pulse; push `{break=0, frame_error, wr_data}`.
- `wr_frame_error` in 1: stop-bit error for `wr_data`, qualified by `wr_valid`.
- `wr_break_valid` in 1: one-cycle pulse; push a break entry `{break=1, frame_error=0, data=8'h00}`.
- `rd_en` in 1: pop head entry; ignored when `empty`.
- `rd_data` out 8: head byte (FWFT); forced to 0 when `empty`.
- `rd_frame_error` out 1: head entry frame-error flag; 0 when `empty`.
- `rd_break` out 1: head entry is a break marker; 0 when `empty`.
- `empty` out 1: no entries.
- `full` out 1: `count == DEPTH`.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; an entry was lost.
- `clr_overflow` in 1: one-cycle clear of `overflow`.
- `rx_thresh` out 1: level indication; see Configuration.

## Operation
- **Storage:** circular buffer of DEPTH × 10 bits, laid out as {break, frame_error, data[7:0]}.
- **Pointers:** `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- **Occupancy:** `count` is held in a separate register. `full` and `empty` are derived from `count` and registered with it.
- **Write request:** `push = wr_valid | wr_break_valid`.
- **Simultaneous pulses:** if `wr_valid` and `wr_break_valid` are both high, the break entry is written, the byte is dropped, and `overflow` is set.
- **Pop:** `pop = rd_en & !empty`. `rd_en` while empty has no effect on any state.
- **Push while full, no pop:** the entry is discarded, `overflow` is set, and pointers and `count` are unchanged.
- **Push and pop, not empty:** both happen; `count` is unchanged, including when `full`.
- **Push and pop while empty:** the pop is ignored and the push is accepted; `count` becomes 1.
- **`overflow`:** set by any discarded entry; cleared by `clr_overflow`. If a set and a clear coincide, set wins.
- **Head outputs:** `rd_data`, `rd_frame_error` and `rd_break` are a combinational read of `mem[rd_ptr]`, gated to 0 while `empty`.
- **Memory reset:** the storage array is not reset. Only pointers, `count`, flags and `overflow` are reset.

## Timing
- **Reset values:** `empty`=1, `full`=0, `count`=0, `overflow`=0, `rx_thresh`=0, `rd_data`=0, `rd_frame_error`=0, `rd_break`=0. Pointers are 0.
- **Reset mid-operation:** all content is lost immediately and asynchronously.
- **Write latency:** a push at edge N is visible at the head from edge N onward. After edge N, `empty` is 0 and `count` is incremented.
- **Pop:** `rd_en` high at edge N advances the head. The next entry (or `empty`=1) appears after edge N.
- **Throughput:** one push and one pop per cycle are sustainable indefinitely.
- **`overflow`:** asserts after the edge at which the discard occurs.

## Configuration
- **Macro:** `UART_RX_FIFO_THRESH_EN`.
- **Defined:** `rx_thresh` is registered and equals `(next count >= THRESHOLD)`, so it is updated in the same cycle as `count`.
- **Undefined:** `rx_thresh` is tied to 0 and the `THRESHOLD` parameter is unused. The port list is identical in both builds.

## Test plan
- **Reset:** assert `rst_n`=0 mid-traffic → all outputs at reset values, `empty`=1, `count`=0.
- **Order and flags:** push 0x41, then 0x42 with `wr_frame_error`=1, then a break → reads return 0x41/fe0/brk0, then 0x42/fe1/brk0, then 0x00/fe0/brk1, then `empty`=1.
- **Fill, overflow, clear:** with DEPTH=16, push 17 bytes 0x00..0x10 and no reads → `full`=1 after 16, `count`=16, `overflow`=1. Reads return 0x00..0x0F. Then pulse `clr_overflow` → `overflow`=0.
- **Simultaneous push/pop:** while full, push 0xAA with `rd_en` in the same cycle → `count` stays 16, `overflow` stays 0, and 0xAA is the last entry read. While empty, push with `rd_en` → `count`=1 and head=pushed byte.
- **Wrap-around:** 40 interleaved push/pop pairs with pseudo-random data → read sequence equals write sequence, `count` never exceeds 2, `rd_en` on empty is ignored.
- **Threshold (macro defined):** with THRESHOLD=8, pushing the 8th byte → `rx_thresh`=1 after that edge. One pop → `rx_thresh`=0. Without the macro, `rx_thresh`=0 throughout.
